// File: rtl/channel_rr_merge.sv
// channel_rr_merge: round-robin merge of K valid/acknowledge input channels
// into one registered output channel. Each output word is {source_id, data}.
//
// Handshake: a word moves on a channel at a posedge where its v and a are
// both 1. A sender holds v and d stable until acknowledged. in_a is
// combinational from in_v, out_a, reset and registered state; out_v and
// out_d are registered.
//
// Optional feature macro: MERGE_BURST_LOCK_EN. When it is defined, the
// in_last port is present. A word with in_last=0 locks arbitration to its
// source until that source sends a word with in_last=1.
module channel_rr_merge #(
  parameter int N   = 8,
  parameter int K   = 4,
  parameter int IdW = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [K-1:0]     in_v,
  input  logic [K*N-1:0]   in_d,
  output logic [K-1:0]     in_a,
`ifdef MERGE_BURST_LOCK_EN
  input  logic [K-1:0]     in_last,
`endif
  output logic             out_v,
  output logic [N+IdW-1:0] out_d,
  input  logic             out_a
);

  logic             out_v_q, out_v_d;
  logic [N+IdW-1:0] out_d_q, out_d_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   sel;
  logic             found;
  logic             grant_ok;
  logic             can_load;
  logic             accept;
  int               idx;

`ifdef MERGE_BURST_LOCK_EN
  logic             lock_q, lock_d;
  logic [IdW-1:0]   lock_idx_q, lock_idx_d;
`endif

  // Round-robin search starting at ptr; a held burst overrides the search.
  always_comb begin
    sel      = ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int j = 0; j < K; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= K) idx = idx - K;
      if (!found && in_v[idx[IdW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IdW-1:0];
      end
    end
    grant_ok = found;
`ifdef MERGE_BURST_LOCK_EN
    if (lock_q) begin
      sel      = lock_idx_q;
      grant_ok = in_v[lock_idx_q];
    end
`endif
  end

  // Acknowledge the selected input when the output register can take a word.
  // Reset masks the acknowledge so no sender believes it transferred.
  always_comb begin
    can_load = !out_v_q || out_a;
    accept   = can_load && grant_ok && !reset;
    in_a     = '0;
    if (accept) in_a[sel] = 1'b1;
  end

  // Next state of the output register, pointer and burst lock.
  always_comb begin
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    ptr_d   = ptr_q;
`ifdef MERGE_BURST_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
`endif
    if (accept) begin
      out_v_d = 1'b1;
      out_d_d = {sel, in_d[int'(sel)*N +: N]};
`ifdef MERGE_BURST_LOCK_EN
      if (in_last[sel]) begin
        lock_d = 1'b0;
        ptr_d  = (int'(sel) == K - 1) ? '0 : sel + IdW'(1);
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = sel;
      end
`else
      ptr_d = (int'(sel) == K - 1) ? '0 : sel + IdW'(1);
`endif
    end else if (out_a) begin
      out_v_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q <= 1'b0;
      out_d_q <= '0;
      ptr_q   <= '0;
`ifdef MERGE_BURST_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      out_v_q <= out_v_d;
      out_d_q <= out_d_d;
      ptr_q   <= ptr_d;
`ifdef MERGE_BURST_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign out_v = out_v_q;
  assign out_d = out_d_q;

endmodule

// File: tb/tb_channel_rr_merge.sv
// Directed bench for channel_rr_merge with N=4, K=3.
module tb_channel_rr_merge;

  localparam int N   = 4;
  localparam int K   = 3;
  localparam int IdW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [K-1:0]     in_v;
  logic [K*N-1:0]   in_d;
  logic [K-1:0]     in_a;
  logic [K-1:0]     in_last;
  logic             out_v;
  logic [N+IdW-1:0] out_d;
  logic             out_a;

  int n_chk  = 0;
  int n_pass = 0;

  channel_rr_merge #(.N(N), .K(K)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_v    (in_v),
    .in_d    (in_d),
    .in_a    (in_a),
`ifdef MERGE_BURST_LOCK_EN
    .in_last (in_last),
`endif
    .out_v   (out_v),
    .out_d   (out_d),
    .out_a   (out_a)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N+IdW-1:0] rr_exp [3];
  logic [N+IdW-1:0] burst_exp [5];
  int               cnt;
  logic             g;

  initial begin
    rr_exp[0] = 6'h01;
    rr_exp[1] = 6'h12;
    rr_exp[2] = 6'h23;
`ifdef MERGE_BURST_LOCK_EN
    burst_exp[0] = 6'h04; burst_exp[1] = 6'h05; burst_exp[2] = 6'h06;
    burst_exp[3] = 6'h12; burst_exp[4] = 6'h12;
`else
    burst_exp[0] = 6'h04; burst_exp[1] = 6'h12; burst_exp[2] = 6'h05;
    burst_exp[3] = 6'h12; burst_exp[4] = 6'h06;
`endif

    // Reset held with all inputs valid
    reset   = 1'b1;
    in_v    = 3'b111;
    in_d    = {4'h3, 4'h2, 4'h1};
    in_last = 3'b000;
    out_a   = 1'b1;
    tick();
    tick();
    check("reset_out_v", 32'(out_v), 32'd0);
    check("reset_out_d", 32'(out_d), 32'd0);
    check("reset_in_a",  32'(in_a),  32'd0);

    // Release: input 0 goes first
    reset = 1'b0;
    #1;
    check("first_in_a", 32'(in_a), 32'b001);
    tick();
    check("first_out_v", 32'(out_v), 32'd1);
    check("first_out_d", 32'(out_d), 32'h01);

    // Single source on input 1
    in_v = 3'b010;
    in_d[1*N +: N] = 4'hA;
    #1;
    check("single_in_a", 32'(in_a), 32'b010);
    tick();
    check("single_out_v", 32'(out_v), 32'd1);
    check("single_out_d", 32'(out_d), 32'h1A);

    // One word from input 2 brings the pointer back to 0
    in_v = 3'b100;
    in_d[1*N +: N] = 4'h2;
    tick();
    check("wrap_out_d", 32'(out_d), 32'h23);

    // All valid, full throughput: ids 0,1,2,0,1,2
    in_v = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_out_v", 32'(out_v), 32'd1);
      check("rr_out_d", 32'(out_d), 32'(rr_exp[i % 3]));
    end

    // Backpressure for 3 cycles
    out_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_a", 32'(in_a), 32'd0);
      tick();
      check("bp_out_v", 32'(out_v), 32'd1);
      check("bp_out_d", 32'(out_d), 32'h23);
    end
    out_a = 1'b1;
    #1;
    check("bp_release_in_a", 32'(in_a), 32'b001);
    tick();
    check("bp_release_out_v", 32'(out_v), 32'd1);
    check("bp_release_out_d", 32'(out_d), 32'h01);

    // Mid-operation reset while stalled
    out_a = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_v", 32'(out_v), 32'd0);
    check("midrst_out_d", 32'(out_d), 32'd0);
    check("midrst_in_a",  32'(in_a),  32'd0);
    tick();
    reset = 1'b0;
    out_a = 1'b1;
    #1;
    check("midrst_grant0", 32'(in_a), 32'b001);

    // Burst: input 0 sends 3 words (last on the third), input 1 always valid
    cnt     = 0;
    in_v    = 3'b011;
    in_last = 3'b000;
    in_d[0 +: N] = 4'h4;
    for (int c = 0; c < 5; c++) begin
      #1;
      g = in_a[0];
      tick();
      check("burst_out_d", 32'(out_d), 32'(burst_exp[c]));
      if (g) cnt++;
      in_v[0]      = (cnt < 3);
      in_last[0]   = (cnt == 2);
      in_d[0 +: N] = 4'(4 + cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
